keypad_scan: RTL and testbench

Memory-mapped 4x4 matrix keypad scanner on the CPU IO bus, parallel to the switch and button readers. Drives keypad columns, samples rows, debounces, and latches one key code per press into a read-to-clear register. Its `keyrdata` output feeds the IO read mux in front of MemOrIO. MemOrIO asserts `keycs` for the keypad address window (0xFFFF_FC80..0xFFFF_FC83).

---
 rtl/keypad_scan.sv | 194 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// Purpose : 4x4 matrix keypad scanner on the CPU IO bus; one debounced key code per press, read-to-clear.
// Latency : press accepted DEBOUNCE_CNT sweeps (4*SCAN_DIV clk each) after it is stable, plus 2 clk of row sync.
// Backpr. : none; a press latched while valid=1 overwrites the code (and flags ovr when KEYPAD_OVERRUN_EN).
//
// Ports: clk/rst (async active-high); keycs/keyread/keyaddr[1:0] bus read strobe and address,
//        keyrdata[15:0] combinational read data; row_i[3:0] active-low rows in; col_o[3:0] active-low column drive.
// Optional: `define KEYPAD_OVERRUN_EN adds the sticky overrun flag at bit 5 of addr 0.
module keypad_scan #(
    parameter logic [15:0] SCAN_DIV     = 16'd5000,
    parameter logic [3:0]  DEBOUNCE_CNT = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keycs,
    input  logic        keyread,
    input  logic [1:0]  keyaddr,
    output logic [15:0] keyrdata,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_DEB_REL   = 2'd3;

    logic [3:0]  row_s1, row_s2;
    logic [15:0] dwell;
    logic [1:0]  col_idx;
    logic        dwell_end, sweep_end;
    logic        hit;
    logic [1:0]  hit_row;
    logic [3:0]  hit_code;
    logic        acc_vld;
    logic [3:0]  acc_code;
    logic        sweep_vld;
    logic [3:0]  sweep_code;
    logic [1:0]  state;
    logic [3:0]  deb_cnt, deb_next, deb_code;
    logic        latch, rd_clr;
    logic [3:0]  code;
    logic        valid;
    logic        ovr;
    logic [15:0] press_cnt;

    // Row synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_i;
            row_s2 <= row_s1;
        end
    end

    // Column driver: each column dwells SCAN_DIV cycles
    assign dwell_end = (dwell == SCAN_DIV - 16'd1);
    assign sweep_end = dwell_end && (col_idx == 2'd3);
    assign col_o     = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= '0;
        end else if (dwell_end) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + 16'd1;
        end
    end

    // Lowest active row in the currently driven column
    always_comb begin
        hit     = 1'b1;
        hit_row = 2'd0;
        if (!row_s2[0])      hit_row = 2'd0;
        else if (!row_s2[1]) hit_row = 2'd1;
        else if (!row_s2[2]) hit_row = 2'd2;
        else if (!row_s2[3]) hit_row = 2'd3;
        else                 hit     = 1'b0;
    end
    assign hit_code = {hit_row, col_idx};

    // Sweep candidate = smallest code seen so far this sweep, including the current sample.
    always_comb begin
        sweep_vld  = acc_vld;
        sweep_code = acc_code;
        if (hit && (!acc_vld || (hit_code < acc_code))) begin
            sweep_vld  = 1'b1;
            sweep_code = hit_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_vld  <= 1'b0;
            acc_code <= '0;
        end else if (dwell_end) begin
            // The column-3 sample closes the sweep; start the next one empty.
            acc_vld  <= sweep_end ? 1'b0 : sweep_vld;
            acc_code <= sweep_end ? 4'd0 : sweep_code;
        end
    end

    // Debounce FSM, stepped once per sweep
    assign deb_next = deb_cnt + 4'd1;

    always_comb begin
        latch = 1'b0;
        if (sweep_end) begin
            case (state)
                ST_IDLE:      latch = sweep_vld && (DEBOUNCE_CNT == 4'd1);
                ST_DEB_PRESS: latch = sweep_vld && (sweep_code == deb_code) && (deb_next >= DEBOUNCE_CNT);
                default:      latch = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            deb_cnt  <= '0;
            deb_code <= '0;
        end else if (sweep_end) begin
            case (state)
                ST_IDLE: if (sweep_vld) begin
                    deb_code <= sweep_code;
                    deb_cnt  <= 4'd1;
                    state    <= latch ? ST_HELD : ST_DEB_PRESS;
                end
                ST_DEB_PRESS: if (sweep_vld && (sweep_code == deb_code)) begin
                    deb_cnt <= deb_next;
                    if (latch) state <= ST_HELD;
                end else begin
                    deb_cnt <= '0;
                    state   <= ST_IDLE;
                end
                ST_HELD: if (!sweep_vld) begin
                    deb_cnt <= 4'd1;
                    state   <= (DEBOUNCE_CNT == 4'd1) ? ST_IDLE : ST_DEB_REL;
                end
                ST_DEB_REL: if (!sweep_vld) begin
                    deb_cnt <= deb_next;
                    if (deb_next >= DEBOUNCE_CNT) state <= ST_IDLE;
                end else begin
                    state <= ST_HELD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result registers; a latch beats a same-cycle read-to-clear.
    assign rd_clr = keycs && keyread && (keyaddr == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code      <= '0;
            valid     <= 1'b0;
            press_cnt <= '0;
        end else if (latch) begin
            code      <= sweep_code;
            valid     <= 1'b1;
            press_cnt <= press_cnt + 16'd1;
        end else if (rd_clr) begin
            valid <= 1'b0;
        end
    end

`ifdef KEYPAD_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr <= 1'b0;
        else if (latch)
            ovr <= valid && !rd_clr;
        else if (rd_clr)
            ovr <= 1'b0;
    end
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        keyrdata = '0;
        if (keycs && keyread) begin
            case (keyaddr)
                2'b00:   keyrdata = {10'b0, ovr, valid, code};
                2'b10:   keyrdata = press_cnt;
                default: keyrdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic        keycs, keyread;
    logic [1:0]  keyaddr;
    logic [15:0] keyrdata;
    logic [3:0]  row_i, col_o;
    logic [15:0] keys;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    keypad_scan #(.SCAN_DIV(16'd4), .DEBOUNCE_CNT(4'd3)) dut (
        .clk(clk), .rst(rst), .keycs(keycs), .keyread(keyread), .keyaddr(keyaddr),
        .keyrdata(keyrdata), .row_i(row_i), .col_o(col_o)
    );

    always #5 clk = ~clk;

    // Keypad model: row r pulled low when its key in the driven column is pressed.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_o[c] && keys[r*4+c]) row_i[r] = 1'b0;
    end

`ifdef KEYPAD_OVERRUN_EN
    localparam logic [15:0] OVR_EXP = 16'h0035;
`else
    localparam logic [15:0] OVR_EXP = 16'h0015;
`endif

    task automatic peek_now(input logic [1:0] a, output logic [15:0] d);
        keycs = 1'b1; keyread = 1'b1; keyaddr = a;
        #1 d = keyrdata;
        keycs = 1'b0; keyread = 1'b0; keyaddr = 2'b00;
    endtask

    task automatic peek(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        peek_now(a, d);
    endtask

    // Read held across one rising edge, so an addr-0 read clears.
    task automatic read_clr(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        keycs = 1'b1; keyread = 1'b1; keyaddr = a;
        #1 d = keyrdata;
        @(negedge clk);
        keycs = 1'b0; keyread = 1'b0; keyaddr = 2'b00;
    endtask

    // Return 1 ns after the edge that starts a new sweep (column 0).
    task automatic sync_sweep();
        logic [3:0] prev;
        int n;
        n = 0;
        prev = col_o;
        @(posedge clk); #1;
        while (!(col_o == 4'b1110 && prev == 4'b0111) && n < 64) begin
            prev = col_o;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) begin
            total_cnt++;
            $display("FAIL sync_sweep: no column wrap seen within 64 cycles, col_o=%b", col_o);
        end
    endtask

    task automatic release_all();
        keys = '0;
        repeat (80) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1; keys = '0; keycs = 1'b0; keyread = 1'b0; keyaddr = 2'b00;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (col_o !== 4'b1110) $display("FAIL por_col: got %b expected 1110", col_o); else pass_cnt++;
        peek_now(2'b00, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL por_addr0: got %h expected 0000", d); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bounce();
        logic [15:0] d;
        sync_sweep();
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (16) @(posedge clk);
            #1;
        end
        keys = '0;
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL bounce_valid: got %h expected 0000", d); else pass_cnt++;
        peek(2'b10, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL bounce_cnt: got %h expected 0000", d); else pass_cnt++;
        release_all();
    endtask

    task automatic test_single_press();
        logic [15:0] d;
        sync_sweep();
        keys = 16'h0040;  // row1/col2 -> code 6
        repeat (47) @(posedge clk);
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL single_early: got %h expected 0000", d); else pass_cnt++;
        @(posedge clk);
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0016) $display("FAIL single_latch: got %h expected 0016", d); else pass_cnt++;
        peek(2'b10, d);
        total_cnt++;
        if (d !== 16'h0001) $display("FAIL single_cnt: got %h expected 0001", d); else pass_cnt++;
        peek(2'b01, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL addr1: got %h expected 0000", d); else pass_cnt++;
        peek(2'b11, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL addr3: got %h expected 0000", d); else pass_cnt++;
        @(negedge clk);
        keycs = 1'b1; keyread = 1'b0; keyaddr = 2'b00;
        #1 d = keyrdata;
        keycs = 1'b0;
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL noread_gate: got %h expected 0000", d); else pass_cnt++;
        read_clr(2'b00, d);
        total_cnt++;
        if (d !== 16'h0016) $display("FAIL single_read: got %h expected 0016", d); else pass_cnt++;
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0006) $display("FAIL single_cleared: got %h expected 0006", d); else pass_cnt++;
        release_all();
    endtask

    task automatic test_multi_hold();
        logic [15:0] d;
        sync_sweep();
        keys = 16'h0204;  // codes 9 and 2 together
        repeat (48) @(posedge clk);
        read_clr(2'b00, d);
        total_cnt++;
        if (d !== 16'h0012) $display("FAIL multi_prio: got %h expected 0012", d); else pass_cnt++;
        repeat (160) @(posedge clk);
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0002) $display("FAIL multi_hold: got %h expected 0002", d); else pass_cnt++;
        // Two release sweeps only, then the key returns: must not re-trigger.
        sync_sweep();
        keys = '0;
        repeat (32) @(posedge clk);
        #1 keys = 16'h0004;
        repeat (80) @(posedge clk);
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0002) $display("FAIL partial_release: got %h expected 0002", d); else pass_cnt++;
        // Full release then a fresh 3-sweep press of code 11.
        sync_sweep();
        keys = '0;
        repeat (48) @(posedge clk);
        #1 keys = 16'h0800;
        repeat (47) @(posedge clk);
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0002) $display("FAIL repress_early: got %h expected 0002", d); else pass_cnt++;
        @(posedge clk);
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h001B) $display("FAIL repress_latch: got %h expected 001b", d); else pass_cnt++;
        peek(2'b10, d);
        total_cnt++;
        if (d !== 16'h0003) $display("FAIL multi_cnt: got %h expected 0003", d); else pass_cnt++;
        read_clr(2'b00, d);
        release_all();
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        sync_sweep();
        keys = 16'h0002;  // code 1
        repeat (48) @(posedge clk);
        #1 keys = '0;
        repeat (48) @(posedge clk);
        #1 keys = 16'h0020;  // code 5
        repeat (48) @(posedge clk);
        #1;
        read_clr(2'b00, d);
        total_cnt++;
        if (d !== OVR_EXP) $display("FAIL overrun: got %h expected %h", d, OVR_EXP); else pass_cnt++;
        peek(2'b00, d);
        total_cnt++;
        if (d !== 16'h0005) $display("FAIL overrun_clr: got %h expected 0005", d); else pass_cnt++;
        peek(2'b10, d);
        total_cnt++;
        if (d !== 16'h0005) $display("FAIL overrun_cnt: got %h expected 0005", d); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [15:0] d;
        sync_sweep();
        keys = 16'h0040;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if (col_o !== 4'b1110) $display("FAIL mid_rst_col: got %b expected 1110", col_o); else pass_cnt++;
        peek_now(2'b00, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL mid_rst_addr0: got %h expected 0000", d); else pass_cnt++;
        peek_now(2'b10, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL mid_rst_addr2: got %h expected 0000", d); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        release_all();
    endtask

    task automatic test_wrap_race();
        logic [15:0] d;
        @(negedge clk);
        force dut.press_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.press_cnt;
        peek(2'b10, d);
        total_cnt++;
        if (d !== 16'hFFFF) $display("FAIL preload: got %h expected ffff", d); else pass_cnt++;
        sync_sweep();
        keys = 16'h0080;  // code 7
        repeat (47) @(posedge clk);
        @(negedge clk);
        keycs = 1'b1; keyread = 1'b1; keyaddr = 2'b00;
        #1 d = keyrdata;
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL race_before: got %h expected 0000", d); else pass_cnt++;
        @(posedge clk);
        #1 keycs = 1'b0; keyread = 1'b0;
        peek_now(2'b00, d);
        total_cnt++;
        if (d !== 16'h0017) $display("FAIL race_latch_wins: got %h expected 0017", d); else pass_cnt++;
        peek_now(2'b10, d);
        total_cnt++;
        if (d !== 16'h0000) $display("FAIL cnt_wrap: got %h expected 0000", d); else pass_cnt++;
        keys = '0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_single_press();
        test_multi_hold();
        test_overrun();
        test_mid_reset();
        test_wrap_race();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
